// File: rtl/wb_arbiter_if.sv
// Write-back requester bus: per-source valid/rd/wd toward the arbiter, one-hot ready back.
// A transfer from requester i happens on a rising edge where req_valid[i] & req_ready[i] are both high.
interface wb_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [5*NUM_REQ-1:0]  req_rd;
  logic [32*NUM_REQ-1:0] req_wd;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (output req_valid, req_rd, req_wd, input req_ready);
  modport slave  (input req_valid, req_rd, req_wd, output req_ready);
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NUM_REQ write-back sources.
// Define WB_ARB_PRIO_EN to give requester 0 fixed top priority over the round-robin group.
module wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  wb_arbiter_if.slave      bus,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [31:0]      rf_wd,
  output logic [IDX_W-1:0] grant_idx
);

`ifdef WB_ARB_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               xfer;
  logic               hold_ptr;
  logic [4:0]         sel_rd;
  logic [31:0]        sel_wd;

  always_comb begin
    int p;
    p        = 0;
    gnt      = '0;
    gnt_idx  = '0;
    xfer     = 1'b0;
    hold_ptr = 1'b0;
    sel_rd   = '0;
    sel_wd   = '0;
    if (!rst && !stall) begin
      // Priority requester 0 wins outright and leaves the rotation untouched.
      if (PRIO_EN && bus.req_valid[0]) begin
        gnt[0]   = 1'b1;
        xfer     = 1'b1;
        hold_ptr = 1'b1;
        sel_rd   = bus.req_rd[4:0];
        sel_wd   = bus.req_wd[31:0];
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          p = int'(rr_ptr) + k;
          if (p >= NUM_REQ) p = p - NUM_REQ;
          if (!xfer && bus.req_valid[p] && !(PRIO_EN && p == 0)) begin
            gnt[p]  = 1'b1;
            xfer    = 1'b1;
            gnt_idx = IDX_W'(p);
            sel_rd  = bus.req_rd[p*5 +: 5];
            sel_wd  = bus.req_wd[p*32 +: 32];
          end
        end
      end
    end
  end

  assign bus.req_ready = gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_wd     <= '0;
      grant_idx <= '0;
    end else if (xfer) begin
      // Writes to x0 still complete the handshake but never reach the register file.
      rf_we     <= (sel_rd != 5'd0);
      rf_rd     <= sel_rd;
      rf_wd     <= sel_wd;
      grant_idx <= gnt_idx;
      if (!hold_ptr)
        rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule
